// File: rtl/mult_div_unit.sv
// Sequential unsigned multiply/divide unit feeding the register file write port.
//
// One iteration per clock. MULU is shift-add (LSB-first), DIVU is restoring
// division (MSB-first). Both share one accumulator pair so the final HI/LO
// load is the same for either operation.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request, accepted only while idle
//   op             0 = MULU, 1 = DIVU
//   operandA       multiplicand / dividend
//   operandB       multiplier / divisor
//   destReg        register receiving LO on completion
//   busy           high while iterating
//   done           one-cycle completion pulse
//   divByZero      valid with done; DIVU with operandB = 0
//   hi, lo         MULU: product high/low; DIVU: remainder/quotient
//   regWrite       write-back strobe (suppressed for register zero)
//   regWriteNum    write-back register number
//   writeData      write-back data, equals lo
module mult_div_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [WIDTH-1:0]  operandA,
  input  logic [WIDTH-1:0]  operandB,
  input  logic [ADDR_W-1:0] destReg,
  output logic              busy,
  output logic              done,
  output logic              divByZero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              regWrite,
  output logic [ADDR_W-1:0] regWriteNum,
  output logic [WIDTH-1:0]  writeData
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic                op_q;
  logic [WIDTH-1:0]    opnd_q;    // multiplicand (MULU) or divisor (DIVU)
  logic [WIDTH:0]      acc_hi_q;  // product high half or partial remainder
  logic [WIDTH-1:0]    acc_lo_q;  // multiplier/product low half or dividend/quotient
  logic [WIDTH-1:0]    hi_q, lo_q;
  logic [ADDR_W-1:0]   dest_q;
  logic                dbz_q;
  logic [CntW-1:0]     cnt_q;

  logic                accept, div_zero, last_iter;
  logic [WIDTH-1:0]    mul_add;
  logic [WIDTH:0]      mul_sum, div_shift, div_trial;
  logic                div_ge;
  logic [WIDTH:0]      iter_hi;
  logic [WIDTH-1:0]    iter_lo;

  assign accept    = (state_q == StIdle) && start;
  assign div_zero  = op && (operandB == '0);
  assign last_iter = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));

  // One iteration of whichever operation is in flight.
  always_comb begin
    mul_add   = acc_lo_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, acc_hi_q[WIDTH-1:0]} + {1'b0, mul_add};
    div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_trial = div_shift - {1'b0, opnd_q};
    if (op_q) begin
      iter_hi = div_ge ? div_trial : div_shift;
      iter_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      // Shift the 33-bit {carry, hi, lo} right by one after the conditional add.
      iter_hi = {1'b0, mul_sum[WIDTH:1]};
      iter_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = div_zero ? StDone : StRun;
      StRun:  if (last_iter) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dest_q   <= '0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      op_q     <= op;
      dest_q   <= destReg;
      dbz_q    <= div_zero;
      cnt_q    <= '0;
      opnd_q   <= op ? operandB : operandA;
      acc_lo_q <= op ? operandA : operandB;
      acc_hi_q <= '0;
      if (div_zero) begin
        hi_q <= operandA;
        lo_q <= '1;
      end
    end else if (state_q == StRun) begin
      acc_hi_q <= iter_hi;
      acc_lo_q <= iter_lo;
      cnt_q    <= cnt_q + CntW'(1);
      if (last_iter) begin
        hi_q <= iter_hi[WIDTH-1:0];
        lo_q <= iter_lo;
      end
    end
  end

  always_comb begin
    busy        = (state_q == StRun);
    done        = (state_q == StDone);
    regWrite    = (state_q == StDone) && (dest_q != '0);
    regWriteNum = dest_q;
    divByZero   = dbz_q;
    hi          = hi_q;
    lo          = lo_q;
    writeData   = lo_q;
  end

endmodule
